// File: rtl/modulo_varredura_coluna_pkg.sv
// Shared defaults and helpers for the LED-matrix column scan path.
// Holds default geometry and timing, plus the coordinate width.
package modulo_varredura_coluna_pkg;

  localparam int N_COL_DEF       = 5;
  localparam int N_ROW_DEF       = 7;
  localparam int DIV_DEF         = 50000;
  localparam int BLINK_TICKS_DEF = 250;
  localparam int CDC_W           = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modulo_prescaler.sv
// Divide-by-DIV tick generator: one-cycle tick on the last count while enabled.
// The count holds while en is low, so a paused scan resumes where it left off.
module modulo_prescaler
  import modulo_varredura_coluna_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = width_for(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; rst is synchronous and outranks en.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/modulo_varredura_coluna.sv
// Column-scan driver for a multiplexed LED matrix with a blinking cursor overlay.
// Cursor coordinate is sampled only at the start of each frame so a frame never tears.
module modulo_varredura_coluna
  import modulo_varredura_coluna_pkg::*;
#(
  parameter int N_COL       = N_COL_DEF,
  parameter int N_ROW       = N_ROW_DEF,
  parameter int DIV         = DIV_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CDC_W-1:0]         cdc,
  input  logic [2:0]               cursor_row,
  input  logic [N_COL*N_ROW-1:0]   frame,
  output logic [N_COL-1:0]         col_en,
  output logic [N_ROW-1:0]         row_out,
  output logic                     cursor_on,
  output logic                     coord_err
);

  localparam int                IW         = width_for(N_COL);
  localparam int                BW         = width_for(BLINK_TICKS);
  localparam logic [IW-1:0]     LAST_COL   = IW'(N_COL - 1);
  localparam logic [BW-1:0]     LAST_BLINK = BW'(BLINK_TICKS - 1);
  localparam logic [CDC_W-1:0]  COL_LIMIT  = CDC_W'(N_COL);
  localparam logic [3:0]        ROW_LIMIT  = 4'(N_ROW);

  logic              tick;
  logic [IW-1:0]     scan_idx;   // column painted on the next tick
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic [CDC_W-1:0]  lat_cdc;
  logic [2:0]        lat_row;

  logic              frame_start;
  logic              blink_wrap;
  logic [IW-1:0]     idx_next;
  logic [CDC_W-1:0]  eff_cdc;
  logic [2:0]        eff_row;
  logic              eff_err;
  logic              eff_phase;
  logic              in_err;
  logic              cursor_hit;
  logic [N_ROW-1:0]  col_data;
  logic [N_ROW-1:0]  row_mask;
  logic [N_COL-1:0]  col_next;
  logic [N_ROW-1:0]  row_next;

  modulo_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign frame_start = (scan_idx == '0);
  assign blink_wrap  = (blink_cnt == LAST_BLINK);
  assign idx_next    = (scan_idx == LAST_COL) ? '0 : scan_idx + 1'b1;
  assign in_err      = (cdc >= COL_LIMIT) || ({1'b0, cursor_row} >= ROW_LIMIT);

  // On a frame-start tick the freshly sampled coordinate and the freshly
  // toggled phase already apply to column 0, so both are forwarded here.
  assign eff_cdc   = frame_start ? cdc        : lat_cdc;
  assign eff_row   = frame_start ? cursor_row : lat_row;
  assign eff_err   = frame_start ? in_err     : coord_err;
  assign eff_phase = blink_wrap  ? ~phase     : phase;

  assign cursor_hit = (eff_cdc == CDC_W'(scan_idx)) && eff_phase && !eff_err;
  assign row_mask   = N_ROW'(1) << eff_row;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    col_data = '0;
    col_next = '0;
    for (int c = 0; c < N_COL; c++) begin
      col_next[c] = (scan_idx == IW'(c));
      if (scan_idx == IW'(c)) begin
        col_data = frame[c*N_ROW +: N_ROW];
      end
    end
    row_next = cursor_hit ? (col_data ^ row_mask) : col_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      lat_cdc   <= '0;
      lat_row   <= '0;
      coord_err <= 1'b0;
      col_en    <= '0;
      row_out   <= '0;
    end else if (!en) begin
      col_en  <= '0;
      row_out <= '0;
    end else if (tick) begin
      scan_idx  <= idx_next;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      phase     <= eff_phase;
      if (frame_start) begin
        lat_cdc   <= cdc;
        lat_row   <= cursor_row;
        coord_err <= in_err;
      end
      col_en  <= col_next;
      row_out <= row_next;
    end
  end

  assign cursor_on = phase;

endmodule

// File: tb/tb_modulo_varredura_coluna.sv
// Directed bench for modulo_varredura_coluna with DIV=4, BLINK_TICKS=2, 5x7 matrix.
// Update n after enable paints column (n-1)%5 with blink phase (n/2)%2.
module tb_modulo_varredura_coluna;

  localparam int N_COL = 5;
  localparam int N_ROW = 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    en  = 1'b0;
  logic [3:0]              cdc = '0;
  logic [2:0]              cursor_row = '0;
  logic [N_COL*N_ROW-1:0]  frame = '0;
  logic [N_COL-1:0]        col_en;
  logic [N_ROW-1:0]        row_out;
  logic                    cursor_on;
  logic                    coord_err;

  int checks = 0;
  int fails  = 0;

  modulo_varredura_coluna #(
    .N_COL       (N_COL),
    .N_ROW       (N_ROW),
    .DIV         (4),
    .BLINK_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cdc        (cdc),
    .cursor_row (cursor_row),
    .frame      (frame),
    .col_en     (col_en),
    .row_out    (row_out),
    .cursor_on  (cursor_on),
    .coord_err  (coord_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N_COL-1:0] exp_col(input int n);
    return N_COL'(1) << ((n - 1) % N_COL);
  endfunction

  function automatic logic exp_phase(input int n);
    return logic'((n / 2) % 2);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One scan tick is four clocks; sample 1 time unit after the updating edge.
  task automatic upd();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; frame = '1; cdc = 4'd2; cursor_row = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b0) begin fails++; $display("FAIL reset_col_en: got %b expected %b", col_en, 5'b0); end
    checks++;
    if (row_out !== 7'b0) begin fails++; $display("FAIL reset_row_out: got %b expected %b", row_out, 7'b0); end
    checks++;
    if (cursor_on !== 1'b0) begin fails++; $display("FAIL reset_cursor_on: got %b expected 0", cursor_on); end
    checks++;
    if (coord_err !== 1'b0) begin fails++; $display("FAIL reset_coord_err: got %b expected 0", coord_err); end
  endtask

  task automatic test_scan();
    do_reset();
    cdc = 4'hF; cursor_row = 3'd0; frame = '0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b0) begin fails++; $display("FAIL scan_no_early_step: got %b expected %b", col_en, 5'b0); end
    @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b00001) begin fails++; $display("FAIL scan_first_step: got %b expected %b", col_en, 5'b00001); end
    for (int n = 2; n <= 6; n++) begin
      upd();
      checks++;
      if (col_en !== exp_col(n) || row_out !== 7'b0) begin
        fails++;
        $display("FAIL scan_step%0d: got col_en=%b row_out=%b expected col_en=%b row_out=%b",
                 n, col_en, row_out, exp_col(n), 7'b0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b00001) begin fails++; $display("FAIL scan_hold: got %b expected %b", col_en, 5'b00001); end
  endtask

  task automatic test_cursor();
    logic [N_ROW-1:0] exp_row;
    do_reset();
    cdc = 4'd2; cursor_row = 3'd3; frame = '0; en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      upd();
      exp_row = (((n - 1) % N_COL) == 2 && exp_phase(n)) ? 7'b0001000 : 7'b0;
      checks++;
      if (col_en !== exp_col(n) || row_out !== exp_row || cursor_on !== exp_phase(n)) begin
        fails++;
        $display("FAIL cursor_step%0d: got col_en=%b row_out=%b cursor_on=%b expected %b %b %b",
                 n, col_en, row_out, cursor_on, exp_col(n), exp_row, exp_phase(n));
      end
    end
  endtask

  task automatic test_xor();
    logic [N_ROW-1:0] exp_row;
    do_reset();
    cdc = 4'd2; cursor_row = 3'd3; frame = 35'h7F << 14; en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      upd();
      if (((n - 1) % N_COL) == 2) exp_row = exp_phase(n) ? 7'b1110111 : 7'b1111111;
      else                        exp_row = 7'b0;
      checks++;
      if (row_out !== exp_row) begin
        fails++;
        $display("FAIL xor_step%0d: got row_out=%b expected %b", n, row_out, exp_row);
      end
    end
  endtask

  task automatic test_move();
    logic [N_ROW-1:0] exp_rows [10];
    exp_rows = '{7'b0, 7'b0, 7'b0001000, 7'b0, 7'b0,
                 7'b0, 7'b0, 7'b0,       7'b0, 7'b0001000};
    do_reset();
    cdc = 4'd2; cursor_row = 3'd3; frame = '0; en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      upd();
      if (n == 2) cdc = 4'd4;
      checks++;
      if (col_en !== exp_col(n) || row_out !== exp_rows[n-1]) begin
        fails++;
        $display("FAIL move_step%0d: got col_en=%b row_out=%b expected %b %b",
                 n, col_en, row_out, exp_col(n), exp_rows[n-1]);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    cdc = 4'd6; cursor_row = 3'd3; frame = '0; en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      upd();
      checks++;
      if (col_en !== exp_col(n) || row_out !== 7'b0 || coord_err !== 1'b1) begin
        fails++;
        $display("FAIL err_step%0d: got col_en=%b row_out=%b coord_err=%b expected %b %b 1",
                 n, col_en, row_out, coord_err, exp_col(n), 7'b0);
      end
    end
    cdc = 4'd0;
    upd();
    checks++;
    if (coord_err !== 1'b0 || row_out !== 7'b0001000) begin
      fails++;
      $display("FAIL err_clear: got coord_err=%b row_out=%b expected 0 %b", coord_err, row_out, 7'b0001000);
    end
    cursor_row = 3'd7;
    repeat (5) upd();
    checks++;
    if (coord_err !== 1'b1 || row_out !== 7'b0) begin
      fails++;
      $display("FAIL err_row_range: got coord_err=%b row_out=%b expected 1 %b", coord_err, row_out, 7'b0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cdc = 4'hF; cursor_row = 3'd5; frame = '0; en = 1'b1;
    repeat (5) upd();
    cdc = 4'd0;
    upd();
    checks++;
    if (col_en !== 5'b00001 || row_out !== 7'b0100000 || cursor_on !== 1'b1 || coord_err !== 1'b0) begin
      fails++;
      $display("FAIL simultaneous_wrap: got col_en=%b row_out=%b cursor_on=%b coord_err=%b expected %b %b 1 0",
               col_en, row_out, cursor_on, coord_err, 5'b00001, 7'b0100000);
    end
  endtask

  task automatic test_disable();
    do_reset();
    cdc = 4'd2; cursor_row = 3'd3; frame = 35'h7F << 14; en = 1'b1;
    repeat (4) upd();
    checks++;
    if (col_en !== 5'b01000) begin fails++; $display("FAIL dis_before: got %b expected %b", col_en, 5'b01000); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (col_en !== 5'b0 || row_out !== 7'b0) begin
        fails++;
        $display("FAIL dis_blank%0d: got col_en=%b row_out=%b expected 0 0", i, col_en, row_out);
      end
    end
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b0) begin fails++; $display("FAIL dis_resume_wait: got %b expected %b", col_en, 5'b0); end
    @(posedge clk);
    #1;
    checks++;
    if (col_en !== 5'b10000 || row_out !== 7'b0) begin
      fails++;
      $display("FAIL dis_resume: got col_en=%b row_out=%b expected %b %b", col_en, row_out, 5'b10000, 7'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (col_en !== 5'b0 || row_out !== 7'b0 || cursor_on !== 1'b0 || coord_err !== 1'b0) begin
      fails++;
      $display("FAIL dis_reset: got col_en=%b row_out=%b cursor_on=%b coord_err=%b expected all zero",
               col_en, row_out, cursor_on, coord_err);
    end
    upd();
    checks++;
    if (col_en !== 5'b00001 || row_out !== 7'b0 || cursor_on !== 1'b0) begin
      fails++;
      $display("FAIL dis_restart: got col_en=%b row_out=%b cursor_on=%b expected %b %b 0",
               col_en, row_out, cursor_on, 5'b00001, 7'b0);
    end
    upd();
    checks++;
    if (col_en !== 5'b00010 || cursor_on !== 1'b1) begin
      fails++;
      $display("FAIL dis_restart2: got col_en=%b cursor_on=%b expected %b 1", col_en, cursor_on, 5'b00010);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_cursor();
    test_xor();
    test_move();
    test_err();
    test_simultaneous();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
